// File: rtl/alu_step_sequencer.sv
// Control-step sequencer for register-register ALU instructions on the bus datapath.
// Walks fetch T0-T2 and execute T3-T5 (T6 for MUL/DIV), driving one step of strobes per clock.
module alu_step_sequencer #(
    parameter int unsigned    NUM_REGS  = 16,
    parameter int unsigned    REG_IDX_W = 4,
    parameter int unsigned    OP_W      = 5,
    parameter logic [OP_W-1:0] OP_MUL   = OP_W'(5'b01111),
    parameter logic [OP_W-1:0] OP_DIV   = OP_W'(5'b10000)
) (
    input  logic                 clk,
    input  logic                 Clear,
    input  logic                 start,
    input  logic [OP_W-1:0]      opcode,
    input  logic [REG_IDX_W-1:0] ra,
    input  logic [REG_IDX_W-1:0] rb,
    input  logic [REG_IDX_W-1:0] rc,
    input  logic                 mem_ready,
    output logic                 PCout,
    output logic                 MARin,
    output logic                 IncPC,
    output logic                 Zin,
    output logic                 PCin,
    output logic                 Read,
    output logic                 MDRin,
    output logic                 MDRout,
    output logic                 IRin,
    output logic                 Yin,
    output logic                 Zlowout,
    output logic                 Zhiout,
    output logic                 HIin,
    output logic                 LOin,
    output logic [NUM_REGS-1:0]  Rin,
    output logic [NUM_REGS-1:0]  Rout,
    output logic [OP_W-1:0]      alu_op,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ERR,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6
    } state_t;

    // One bit wider than an index so NUM_REGS == 2**REG_IDX_W is representable.
    localparam logic [REG_IDX_W:0] REG_LIMIT = (REG_IDX_W+1)'(NUM_REGS);

    state_t state, nxt_state;

    logic [OP_W-1:0]      op_q;
    logic [REG_IDX_W-1:0] ra_q, rb_q, rc_q;
    logic                 is_muldiv;
    logic                 bad_idx;

    logic pcout_d, marin_d, incpc_d, zin_d, pcin_d, read_d, mdrin_d;
    logic mdrout_d, irin_d, yin_d, zlowout_d, zhiout_d, hiin_d, loin_d;
    logic [NUM_REGS-1:0] rin_d, rout_d;
    logic [OP_W-1:0]     alu_op_d;
    logic                busy_d, done_d, err_d;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            r[i] = (idx == REG_IDX_W'(i));
        end
        return r;
    endfunction

    assign is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign bad_idx   = ({1'b0, ra} >= REG_LIMIT) ||
                       ({1'b0, rb} >= REG_LIMIT) ||
                       ({1'b0, rc} >= REG_LIMIT);

    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            state <= S_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            op_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
            rc_q <= '0;
        end else if (state == S_IDLE && start) begin
            op_q <= opcode;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
        end
    end

    always_comb begin
        nxt_state = state;
        unique case (state)
            S_IDLE: if (start) nxt_state = bad_idx ? S_ERR : S_T0;
            S_ERR:  nxt_state = S_IDLE;
            S_T0:   nxt_state = S_T1;
            S_T1:   if (mem_ready) nxt_state = S_T2;
            S_T2:   nxt_state = S_T3;
            S_T3:   nxt_state = S_T4;
            S_T4:   nxt_state = S_T5;
            S_T5:   nxt_state = is_muldiv ? S_T6 : S_IDLE;
            S_T6:   nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so they line up
    // with the state register yet come straight from flops.
    always_comb begin
        pcout_d   = 1'b0;
        marin_d   = 1'b0;
        incpc_d   = 1'b0;
        zin_d     = 1'b0;
        pcin_d    = 1'b0;
        read_d    = 1'b0;
        mdrin_d   = 1'b0;
        mdrout_d  = 1'b0;
        irin_d    = 1'b0;
        yin_d     = 1'b0;
        zlowout_d = 1'b0;
        zhiout_d  = 1'b0;
        hiin_d    = 1'b0;
        loin_d    = 1'b0;
        rin_d     = '0;
        rout_d    = '0;
        alu_op_d  = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        busy_d    = (nxt_state != S_IDLE);
        unique case (nxt_state)
            S_ERR: err_d = 1'b1;
            S_T0: begin
                pcout_d = 1'b1;
                marin_d = 1'b1;
                incpc_d = 1'b1;
                zin_d   = 1'b1;
            end
            S_T1: begin
                zlowout_d = 1'b1;
                pcin_d    = 1'b1;
                read_d    = 1'b1;
                mdrin_d   = 1'b1;
            end
            S_T2: begin
                mdrout_d = 1'b1;
                irin_d   = 1'b1;
            end
            S_T3: begin
                rout_d = onehot(rb_q);
                yin_d  = 1'b1;
            end
            S_T4: begin
                rout_d   = onehot(rc_q);
                zin_d    = 1'b1;
                alu_op_d = op_q;
            end
            S_T5: begin
                zlowout_d = 1'b1;
                if (is_muldiv) begin
                    loin_d = 1'b1;
                end else begin
                    rin_d  = onehot(ra_q);
                    done_d = 1'b1;
                end
            end
            S_T6: begin
                zhiout_d = 1'b1;
                hiin_d   = 1'b1;
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            PCout   <= 1'b0;
            MARin   <= 1'b0;
            IncPC   <= 1'b0;
            Zin     <= 1'b0;
            PCin    <= 1'b0;
            Read    <= 1'b0;
            MDRin   <= 1'b0;
            MDRout  <= 1'b0;
            IRin    <= 1'b0;
            Yin     <= 1'b0;
            Zlowout <= 1'b0;
            Zhiout  <= 1'b0;
            HIin    <= 1'b0;
            LOin    <= 1'b0;
            Rin     <= '0;
            Rout    <= '0;
            alu_op  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            PCout   <= pcout_d;
            MARin   <= marin_d;
            IncPC   <= incpc_d;
            Zin     <= zin_d;
            PCin    <= pcin_d;
            Read    <= read_d;
            MDRin   <= mdrin_d;
            MDRout  <= mdrout_d;
            IRin    <= irin_d;
            Yin     <= yin_d;
            Zlowout <= zlowout_d;
            Zhiout  <= zhiout_d;
            HIin    <= hiin_d;
            LOin    <= loin_d;
            Rin     <= rin_d;
            Rout    <= rout_d;
            alu_op  <= alu_op_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule
